// File: rtl/seq_divider_if.sv
// Divider request/result bundle: master drives operands and start, slave returns results and status.
// The sign field exists only when SEQ_DIVIDER_SIGNED_EN is defined.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic             sign;

    modport master (
        output start, dividend, divisor, sign,
        input  quotient, remainder, busy, done, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor, sign,
        output quotient, remainder, busy, done, div_by_zero
    );
`else
    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
`endif
endinterface

// File: rtl/seq_divider.sv
// Restoring divider: done is asserted WIDTH cycles after the accept (the next cycle for divisor 0); SEQ_DIVIDER_SIGNED_EN adds signed mode.
// Backpressure: start is ignored while busy; results are held until the next accepted start.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic             accept;

    // The partial remainder never reaches bit WIDTH-1 before its shift, so dropping it is lossless.
    assign shifted = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
    assign trial   = {1'b0, shifted} - {1'b0, d_reg};
    assign q_next  = {q_reg[WIDTH-2:0], ~trial[WIDTH]};
    assign r_next  = trial[WIDTH] ? shifted : trial[WIDTH-1:0];
    assign accept  = bus.start && (state != RUN);

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;

    assign dvd_mag = (bus.sign && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    assign dvs_mag = (bus.sign && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
    // Most-negative / -1 falls out naturally: magnitude 2^(WIDTH-1) negates to itself.
    assign q_fin   = neg_q ? -q_next : q_next;
    assign r_fin   = neg_r ? -r_next : r_next;
`else
    assign dvd_mag = bus.dividend;
    assign dvs_mag = bus.divisor;
    assign q_fin   = q_next;
    assign r_fin   = r_next;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            d_reg           <= '0;
            q_reg           <= '0;
            r_reg           <= '0;
            cnt             <= '0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state         <= DONE;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        bus.quotient  <= q_fin;
                        bus.remainder <= r_fin;
                    end
                end
                default: begin
                    if (accept) begin
                        d_reg           <= dvs_mag;
                        q_reg           <= dvd_mag;
                        r_reg           <= '0;
                        cnt             <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        neg_q           <= bus.sign && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        neg_r           <= bus.sign && bus.dividend[WIDTH-1];
`endif
                        if (bus.divisor == '0) begin
                            state           <= DONE;
                            bus.busy        <= 1'b0;
                            bus.done        <= 1'b1;
                            bus.quotient    <= '1;
                            bus.remainder   <= bus.dividend;
                            bus.div_by_zero <= 1'b1;
                        end else begin
                            state           <= RUN;
                            bus.busy        <= 1'b1;
                            bus.done        <= 1'b0;
                            bus.div_by_zero <= 1'b0;
                        end
                    end else begin
                        state    <= IDLE;
                        bus.done <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
